pll_lock_sequencer: RTL
=======================

// Module: pll_lock_sequencer
// PURPOSE
//  Reset/lock supervisor for the 300 MHz rPLL. Runs on the free-running 100 MHz
//  board clock, drives the PLL reset input, synchronises and qualifies the PLL
//  LOCK output, and releases the core reset only after lock has been stable.
//  Retries the PLL on lock timeout and re-sequences on loss of lock.
// PARAMETERS
//  RESET_CYCLES  16     cycles pll_reset is held high per attempt (>=1)
//  LOCK_STABLE   256    consecutive synced-lock cycles required before release (>=1)
//  LOCK_TIMEOUT  10000  max cycles in WAIT_LOCK per attempt (> LOCK_STABLE)
//  MAX_RETRIES   4      failed attempts before FAIL (>=1)
//  CNT_W         8      width of retry_cnt / relock_cnt
// PORTS
//  clk         in   1      100 MHz free-running reference clock (also PLL clkin)
//  rst_n       in   1      async active-low reset
//  pll_lock    in   1      PLL LOCK, asynchronous to clk
//  restart     in   1      1-cycle pulse: force a new sequence from any state
//  pll_reset   out  1      to PLL reset, active high
//  core_rst_n  out  1      active-low core reset; consumers re-sync deassertion
//  ready       out  1      1 in RUN
//  fail        out  1      1 in FAIL
//  retry_cnt   out  CNT_W  timeouts in the current attempt series
//  relock_cnt  out  CNT_W  loss-of-lock events since reset, saturating
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
//  - rst_n low (async): state=ASSERT_RST, counters 0; pll_reset=1, core_rst_n=0,
//    ready=0, fail=0, retry_cnt=0, relock_cnt=0. All outputs registered.
//  - pll_lock passes through a 2-flop synchroniser (reset 0) -> lock_s.
//  - ASSERT_RST: pll_reset=1 for exactly RESET_CYCLES clk edges after entry
//    (after rst_n release: first RESET_CYCLES edges), then -> WAIT_LOCK.
//    Clears stable/timeout counters.
//  - WAIT_LOCK: pll_reset=0, core_rst_n=0. Timeout counter increments every
//    cycle. Stable counter increments while lock_s=1, clears to 0 when lock_s=0.
//    stable reaches LOCK_STABLE -> RUN, retry_cnt cleared.
//    timeout reaches LOCK_TIMEOUT -> retry_cnt+1; if new value == MAX_RETRIES ->
//    FAIL, else -> ASSERT_RST.
//    Stable completion and timeout on the same edge: stable wins (-> RUN).
//  - Timing: core_rst_n and ready rise after the (LOCK_STABLE+1)th edge following
//    the edge that first samples pll_lock=1 (2-flop latency included).
//  - RUN: core_rst_n=1, ready=1. lock_s=0 on an edge -> on that edge go
//    ASSERT_RST: core_rst_n=0, ready=0, pll_reset=1 next cycle.
//    relock_cnt+1, saturating at 2^CNT_W-1.
//  - FAIL: pll_reset=0, core_rst_n=0, fail=1. Held until restart or rst_n.
//  - restart=1 in any state -> ASSERT_RST on that edge. Clears fail, retry_cnt,
//    stable and timeout counters. relock_cnt not changed.
//    Takes priority over all other transitions.
//  - No other state; illegal encodings -> ASSERT_RST.
// TESTING
//  (params RESET_CYCLES=4 LOCK_STABLE=8 LOCK_TIMEOUT=64 MAX_RETRIES=3 CNT_W=4;
//   PLL model raises lock N cycles after pll_reset falls)
//  1 rst_n release, N=20 -> pll_reset high 4 edges; core_rst_n rises 9 edges after
//    lock is first sampled; ready=1, retry_cnt=0.
//  2 lock pulses 3 cycles high at N=10, then steady from N=30 ->
//    stable count restarts; core_rst_n rises 9 edges after the second rise.
//  3 lock never rises -> 3 pll_reset pulses, 64-cycle waits; fail=1, retry_cnt=3,
//    pll_reset=0, core_rst_n=0 held. Then restart pulse -> fail=0, new 4-cycle pulse.
//  4 in RUN drop lock 1 cycle -> core_rst_n=0 within 3 edges, relock_cnt=1;
//    re-lock -> RUN again. Repeat 20x -> relock_cnt saturates at 15.
//  5 rst_n pulsed low mid-WAIT_LOCK and in RUN -> outputs at reset values
//    immediately (async), full sequence restarts.
//  6 lock rises so stable completes on exactly the 64th WAIT_LOCK edge -> RUN,
//    no retry increment.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// Reset/lock supervisor for the rPLL: pulses the PLL reset, qualifies the
// synchronised LOCK output, releases the core reset, retries on timeout.
module pll_lock_sequencer #(
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned LOCK_TIMEOUT = 10000,
  parameter int unsigned MAX_RETRIES  = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             restart,
  output logic             pll_reset,
  output logic             core_rst_n,
  output logic             ready,
  output logic             fail,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] relock_cnt
);

  localparam int unsigned RW = $clog2(RESET_CYCLES + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ASSERT_RST = 2'd0,
    WAIT_LOCK  = 2'd1,
    RUN        = 2'd2,
    FAIL       = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [RW-1:0]    rst_cnt, rst_cnt_d;
  logic [SW-1:0]    stable_cnt, stable_d, stable_inc;
  logic [TW-1:0]    timeout_cnt, timeout_d, timeout_inc;
  logic [CNT_W-1:0] retry_d, retry_inc, relock_d;
  logic             lock_meta, lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_d     = state;
    rst_cnt_d   = '0;
    stable_d    = stable_cnt;
    timeout_d   = timeout_cnt;
    retry_d     = retry_cnt;
    relock_d    = relock_cnt;
    stable_inc  = lock_s ? stable_cnt + 1'b1 : '0;
    timeout_inc = timeout_cnt + 1'b1;
    retry_inc   = retry_cnt + 1'b1;
    if (restart) begin
      state_d   = ASSERT_RST;
      retry_d   = '0;
      stable_d  = '0;
      timeout_d = '0;
    end else begin
      case (state)
        ASSERT_RST: begin
          stable_d  = '0;
          timeout_d = '0;
          if (rst_cnt == RW'(RESET_CYCLES - 1)) state_d = WAIT_LOCK;
          else rst_cnt_d = rst_cnt + 1'b1;
        end
        WAIT_LOCK: begin
          stable_d  = stable_inc;
          timeout_d = timeout_inc;
          // stable completion is tested first so it wins a same-edge timeout
          if (stable_inc == SW'(LOCK_STABLE)) begin
            state_d = RUN;
            retry_d = '0;
          end else if (timeout_inc == TW'(LOCK_TIMEOUT)) begin
            retry_d = retry_inc;
            state_d = (retry_inc == CNT_W'(MAX_RETRIES)) ? FAIL : ASSERT_RST;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d = ASSERT_RST;
            if (relock_cnt != '1) relock_d = relock_cnt + 1'b1;
          end
        end
        FAIL:    state_d = FAIL;
        default: state_d = ASSERT_RST;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ASSERT_RST;
      rst_cnt     <= '0;
      stable_cnt  <= '0;
      timeout_cnt <= '0;
      retry_cnt   <= '0;
      relock_cnt  <= '0;
      pll_reset   <= 1'b1;
      core_rst_n  <= 1'b0;
      ready       <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_d;
      rst_cnt     <= rst_cnt_d;
      stable_cnt  <= stable_d;
      timeout_cnt <= timeout_d;
      retry_cnt   <= retry_d;
      relock_cnt  <= relock_d;
      pll_reset   <= (state_d == ASSERT_RST);
      core_rst_n  <= (state_d == RUN);
      ready       <= (state_d == RUN);
      fail        <= (state_d == FAIL);
    end
  end

endmodule
